// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-deep skid buffer feeding the IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [6:0]  op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  // FETCH issues, WAIT expects the response, HOLD parks a stalled response,
  // DISCARD swallows the response of a request killed by a redirect.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next-state and IF/ID update; flush wins over stall, stall holds IF/ID.
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    if (flush_i) begin
      fpc_d   = {redirect_pc_i[31:2], 2'b00};
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      // The skid contents die with the redirect; HOLD is left unconditionally.
      unique case (state_q)
        ST_FETCH: state_d = ST_DISCARD;
        ST_WAIT:  state_d = imem_valid_i ? ST_FETCH : ST_DISCARD;
        ST_HOLD:  state_d = ST_FETCH;
        default:  state_d = imem_valid_i ? ST_FETCH : ST_DISCARD;
      endcase
    end else begin
      // An unstalled cycle that does not load a real entry shows a bubble.
      if (!stall_i) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      unique case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_valid_i) begin
            fpc_d = fpc_q + 32'd4;
            if (stall_i) begin
              skid_instr_d = imem_rdata_i;
              skid_pc_d    = fpc_q;
              state_d      = ST_HOLD;
            end else begin
              instr_d = imem_rdata_i;
              pc_d    = fpc_q;
              valid_d = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            instr_d = skid_instr_q;
            pc_d    = skid_pc_q;
            valid_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
        default: begin
          if (imem_valid_i) begin
            state_d = ST_FETCH;
          end
        end
      endcase
    end
  end

  // State, fetch PC, skid buffer and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      fpc_q        <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  // Reset parks the FSM in FETCH, so the request is gated until reset drops.
  assign imem_req_o  = (state_q == ST_FETCH) && !rst_i;
  assign imem_addr_o = fpc_q;
  assign instr_o     = instr_q;
  assign op_o        = instr_q[6:0];
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + 32'd4;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a queue-based memory and pipeline model
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] instr_o;
  logic [6:0]  op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .op_o         (op_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .valid_o      (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  entry_t      exp_q[$];
  logic [31:0] exp_next = RESET_PC;
  bit          mem_busy = 0;
  bit          mem_live = 0;
  int          mem_cnt  = 0;
  int          lat_force = 1;
  logic [31:0] mem_addr = 32'd0;
  bit          last_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at posedge+1: drive, let the edge pass, update the model.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] rpc, input bit do_rst);
    bit          r_seen;
    logic [31:0] a_seen;
    entry_t      e;
    stall_i       = st;
    flush_i       = fl;
    redirect_pc_i = rpc;
    imem_valid_i  = mem_busy && (mem_cnt == 0);
    imem_rdata_i  = imem_valid_i ? mem_word(mem_addr) : $urandom;
    if (do_rst) begin
      #1 rst_i = 1'b1;
      #1;
      check("rst_async_valid", valid_o, 0);
      check("rst_async_instr", instr_o, NOP);
      check("rst_async_pc", pc_o, 0);
      check("rst_async_req", imem_req_o, 0);
      #1 rst_i = 1'b0;
      exp_q.delete();
      mem_live = 0;
      exp_next = RESET_PC;
      imem_valid_i = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    r_seen = imem_req_o;
    a_seen = imem_addr_o;
    @(posedge clk);
    #1;
    if (imem_valid_i) begin
      mem_busy = 0;
      if (mem_live) begin
        e.pc    = mem_addr;
        e.instr = mem_word(mem_addr);
        exp_q.push_back(e);
        exp_next = mem_addr + 32'd4;
      end
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    if (r_seen) begin
      check("one_outstanding", mem_busy, 0);
      mem_busy = 1;
      mem_live = 1;
      mem_addr = a_seen;
      mem_cnt  = ((lat_force != 0) ? lat_force : int'($urandom_range(1, 3))) - 1;
    end
    if (fl) begin
      exp_q.delete();
      mem_live = 0;
      exp_next = rpc & 32'hFFFF_FFFC;
    end
    last_req = r_seen;
  endtask

  // Monitor: mid-cycle, check the IF/ID entry consumed at the coming edge and the fetch address.
  initial begin
    bit          p_ok, p_st, p_fl;
    logic        p_valid;
    logic [31:0] p_instr, p_pc;
    entry_t      e;
    p_ok = 0; p_st = 0; p_fl = 0; p_valid = 0; p_instr = 0; p_pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (p_ok && p_fl) begin
          check("flush_bubble", valid_o, 0);
        end else if (p_ok && p_st) begin
          check("hold_valid", valid_o, p_valid);
          check("hold_instr", instr_o, p_instr);
          check("hold_pc", pc_o, p_pc);
        end
        if (!valid_o) check("bubble_instr", instr_o, NOP);
        if (imem_req_o) check("fetch_addr", imem_addr_o, exp_next);
        if (valid_o && !stall_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", valid_o, 0);
          end else begin
            e = exp_q.pop_front();
            n_pops++;
            check("sb_pc", pc_o, e.pc);
            check("sb_instr", instr_o, e.instr);
            check("sb_op", op_o, e.instr[6:0]);
            check("sb_pc_plus4", pc_plus4_o, e.pc + 32'd4);
          end
        end
      end
      p_ok = !rst_i; p_st = stall_i; p_fl = flush_i;
      p_valid = valid_o; p_instr = instr_o; p_pc = pc_o;
    end
  end

  // Stimulus: directed scenarios, random traffic, then an asynchronous reset mid-WAIT.
  initial begin
    bit found;
    logic [31:0] r;
    repeat (2) @(negedge clk);
    check("reset_req", imem_req_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_instr", instr_o, NOP);
    check("reset_pc", pc_o, 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    exp_next = RESET_PC;
    lat_force = 1;

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("s1_valid", valid_o, 1);
    check("s1_instr", instr_o, 32'h0050_0093);
    check("s1_op", op_o, 7'b0010011);
    check("s1_pc", pc_o, 32'h0);
    check("s1_pc_plus4", pc_plus4_o, 32'h4);
    check("s1_next_req", imem_req_o, 1);
    check("s1_next_addr", imem_addr_o, 32'h4);

    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("s2_held_valid", valid_o, 0);
    check("s2_no_req", imem_req_o, 0);
    cycle(0, 0, 0, 0);
    check("s2_skid_valid", valid_o, 1);
    check("s2_skid_pc", pc_o, 32'h4);
    check("s2_skid_instr", instr_o, mem_word(32'h4));

    lat_force = 3;
    cycle(0, 0, 0, 0);
    lat_force = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h103, 0);
    check("s3_flush_valid", valid_o, 0);
    cycle(0, 0, 0, 0);
    check("s3_dropped_valid", valid_o, 0);
    check("s3_req", imem_req_o, 1);
    check("s3_addr", imem_addr_o, 32'h100);

    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 32'hFFFF_FFFE, 0);
    check("s4_valid", valid_o, 0);
    check("s4_instr", instr_o, NOP);
    check("s4_req", imem_req_o, 1);
    check("s4_addr", imem_addr_o, 32'hFFFF_FFFC);

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("s5_valid", valid_o, 1);
    check("s5_pc", pc_o, 32'hFFFF_FFFC);
    check("s5_pc_plus4", pc_plus4_o, 32'h0);
    check("s5_wrap_addr", imem_addr_o, 32'h0);
    cycle(0, 0, 0, 0);

    lat_force = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, r, 0);
    end

    lat_force = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, 0, 0);
      found = last_req;
    end
    check("s6_req_found", found, 1);
    lat_force = 1;
    cycle(0, 0, 0, 1);
    check("s6_restart_valid", valid_o, 0);
    cycle(0, 0, 0, 0);
    check("s6_restart_pc", pc_o, RESET_PC);
    check("s6_restart_instr", instr_o, mem_word(RESET_PC));
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    check("progress", n_pops > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble encoding (addi x0,x0,0) driven on instr_o when the output is not valid.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold the IF/ID outputs.
- flush_i  in  1  redirect request.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request, one cycle per fetch.
- imem_addr_o  out  32  fetch address.
- imem_valid_i  in  1  response strobe, arrives 1 or more cycles after the request.
- imem_rdata_i  in  32  instruction word, qualified by imem_valid_i.
- instr_o  out  32  IF/ID instruction.
- op_o  out  7  instr_o[6:0], the opcode feeding the main decoder.
- pc_o  out  32  IF/ID PC.
- pc_plus4_o  out  32  pc_o+4, the JAL/JALR link value.
- valid_o  out  1  IF/ID entry valid.

Function
REQ-004 SHALL hold an internal fetch PC register (fpc) and one skid buffer (instruction plus PC).
REQ-005 SHALL implement a 4-state FSM: FETCH, WAIT, HOLD, DISCARD. At most one request is outstanding.
REQ-006 In FETCH, SHALL assert imem_req_o=1 with imem_addr_o=fpc, then go to WAIT next cycle. imem_req_o SHALL be 0 in all other states.
REQ-007 In WAIT, when imem_valid_i=1 and stall_i=0:
- load instr_o=imem_rdata_i, pc_o=fpc, valid_o=1;
- set fpc=fpc+4 (mod 2^32);
- go to FETCH.
REQ-008 In WAIT, when imem_valid_i=1 and stall_i=1: capture the word and fpc in the skid buffer, set fpc=fpc+4, go to HOLD.
REQ-009 In HOLD, when stall_i=0: load the IF/ID outputs from the skid buffer with valid_o=1, go to FETCH.
REQ-010 On any cycle with stall_i=0 where REQ-007 and REQ-009 do not apply, the IF/ID entry SHALL become a bubble: valid_o=0, instr_o=NOP_INSTR.
REQ-011 While stall_i=1 and flush_i=0, the IF/ID outputs SHALL hold their values.
REQ-012 flush_i SHALL take priority over stall_i. On flush:
- fpc = {redirect_pc_i[31:2],2'b00};
- IF/ID becomes a bubble;
- the skid buffer is dropped.
REQ-013 Flush next-state rules:
- from FETCH -> DISCARD;
- from WAIT with imem_valid_i=1 -> FETCH (the response is dropped);
- from WAIT with imem_valid_i=0 -> DISCARD;
- from HOLD -> FETCH;
- from DISCARD -> DISCARD, or FETCH if imem_valid_i=1.
fpc SHALL take the newest redirect in every case.
REQ-014 In DISCARD, the response SHALL be dropped when imem_valid_i=1, and the FSM goes to FETCH.
REQ-015 imem_valid_i in FETCH or HOLD is a protocol error: it SHALL be ignored and SHALL NOT change state.
REQ-016 op_o and pc_plus4_o SHALL be combinational from the IF/ID registers.
REQ-017 Timing with a 1-cycle memory and no stall: a request at cycle n gives imem_valid_i at n+1 and valid_o=1 at n+2. Throughput is one instruction per 2 cycles.

Reset
REQ-018 While rst_i=1, SHALL asynchronously set:
- FSM=FETCH, fpc=RESET_PC;
- valid_o=0, instr_o=NOP_INSTR, pc_o=0;
- skid buffer empty.
REQ-019 imem_req_o SHALL be 0 while rst_i=1. The first request SHALL be issued in the first cycle after rst_i falls.
REQ-020 Reset asserted mid-WAIT SHALL abandon the outstanding response. A response arriving after reset releases SHALL be ignored (the FSM is in FETCH, see REQ-015).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, 1-cycle memory returning 32'h00500093 -> imem_addr_o=0x0, then instr_o=32'h00500093, op_o=7'b0010011, pc_o=0x0, pc_plus4_o=0x4, valid_o=1; the next request addr is 0x4.
- Stall asserted 3 cycles while a response arrives in WAIT -> FSM goes to HOLD, IF/ID unchanged; on stall release the buffered word appears with pc_o=0x4.
- flush_i with redirect_pc_i=0x103 during WAIT, memory latency 3 -> old response dropped, valid_o=0, next imem_addr_o=0x100.
- flush_i and stall_i together in HOLD -> bubble (valid_o=0, instr_o=32'h00000013), next fetch at the redirect target.
- fpc=0xFFFF_FFFC fetch completes -> next imem_addr_o=0x0000_0000.
- rst_i pulsed asynchronously mid-WAIT -> outputs reset with no clock edge; a late imem_valid_i is ignored and the fetch restarts at RESET_PC.
